// File: rtl/serial_rx_10k.sv
// serial_rx_10k: receiver-side bit recovery for the 10 kbit/s Sender link.
// Oversamples rx_in, finds the start bit, samples each bit at its midpoint,
// assembles an LSB-first word and checks the stop bit before presenting it.
// Optional feature macro: SERIAL_RX_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits, and a parity mismatch turns the frame into frame_err.
module serial_rx_10k #(
  parameter int CLKS_PER_BIT = 2000,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic                 start_edge;
  logic                 stop_good;

`ifdef SERIAL_RX_PARITY_EN
  logic                 par_err;
`endif

  // Two-flop synchroniser plus one history flop for edge detection; sync_fill
  // marks when the reset values have been flushed out of the chain.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // A start needs a real high-to-low transition seen after the line was high
  // in IDLE, so a line stuck low after reset or a break never starts a frame.
  always_comb begin
    start_edge = armed & rx_prev & ~rx_s;
`ifdef SERIAL_RX_PARITY_EN
    stop_good  = rx_s & ~par_err;
`else
    stop_good  = rx_s;
`endif
  end

  // Frame FSM with registered strobes, busy flag and the received word.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      armed      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          armed <= sync_fill[1] & rx_s;
          if (start_edge) begin
            state   <= START;
            clk_cnt <= '0;
            busy    <= 1'b1;
            armed   <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              bit_idx   <= '0;
              shift_reg <= '0;
              state     <= DATA;
`ifdef SERIAL_RX_PARITY_EN
              par_err   <= 1'b0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            par_err <= (^shift_reg) ^ rx_s;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (stop_good) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          busy    <= 1'b0;
          armed   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_10k.sv
// tb_serial_rx_10k: directed bench for serial_rx_10k at 16 clocks per bit.
// Honours SERIAL_RX_PARITY_EN when defined (adds the parity bit and parity cases).
module tb_serial_rx_10k;

  localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_CYC = 11 * CPB;
`else
  localparam int FRAME_CYC = 10 * CPB;
`endif
  localparam int LATENCY = FRAME_CYC - 5;

  logic       clock_in;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  int dv_count = 0;
  int fe_count = 0;
  int overlap_count = 0;
  int wide_count = 0;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [7:0] dv_vals[$];
  int dv_cycles[$];
  int last_start = 0;
  int exp_dv = 0;
  int exp_fe = 0;
  int diff;

  serial_rx_10k #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // 100 MHz bench clock; the design only cares about cycles
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Cycle counter for latency measurements
  always @(posedge clock_in) cycle++;

  // Pulse monitor sampling on the inactive edge
  always @(negedge clock_in) begin
    if (data_valid) begin
      dv_count++;
      dv_vals.push_back(data_out);
      dv_cycles.push_back(cycle);
    end
    if (frame_err) fe_count++;
    if (data_valid && frame_err) overlap_count++;
    if ((data_valid && dv_prev) || (frame_err && fe_prev)) wide_count++;
    dv_prev = data_valid;
    fe_prev = frame_err;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one full frame: start, LSB-first data, optional parity, stop
  task automatic apply_stimulus(input logic [7:0] val, input logic par_bit,
                                input logic stop_bit);
    last_start = cycle;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clock_in);
    for (int i = 0; i < 8; i++) begin
      rx_in = val[i];
      repeat (CPB) @(negedge clock_in);
    end
`ifdef SERIAL_RX_PARITY_EN
    rx_in = par_bit;
    repeat (CPB) @(negedge clock_in);
`endif
    rx_in = stop_bit;
    repeat (CPB) @(negedge clock_in);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clock_in);
  endtask

  initial begin
    reset = 1'b0;
    rx_in = 1'b0;
    #3 reset = 1'b1;
    repeat (3) @(negedge clock_in);
    check_output("rst_data_out", data_out, 8'h00);
    check_output("rst_data_valid", data_valid, 1'b0);
    check_output("rst_frame_err", frame_err, 1'b0);
    check_output("rst_busy", busy, 1'b0);

    // line held low through reset release must not start a frame
    reset = 1'b0;
    repeat (40) @(negedge clock_in);
    check_output("low_line_busy", busy, 1'b0);
    check_output("low_line_pulses", dv_count + fe_count, 0);
    idle(40);

    // frame 0xA5, good stop
    apply_stimulus(8'hA5, ^8'hA5, 1'b1);
    exp_dv++;
    check_output("a5_busy_after", busy, 1'b0);
    idle(32);
    check_output("a5_dv_count", dv_count, exp_dv);
    check_output("a5_fe_count", fe_count, exp_fe);
    check_output("a5_data_out", data_out, 8'hA5);
    diff = (dv_cycles.size() > 0) ? dv_cycles[dv_cycles.size()-1] - last_start : -1;
    $display("[TB] 0xA5 latency %0d cycles", diff);
    check_output("a5_latency_ok", (diff >= LATENCY - 1 && diff <= LATENCY + 1), 1'b1);

    // 4-cycle low glitch on an idle line
    rx_in = 1'b0;
    repeat (4) @(negedge clock_in);
    check_output("glitch_busy_high", busy, 1'b1);
    rx_in = 1'b1;
    repeat (8) @(negedge clock_in);
    check_output("glitch_busy_dropped", busy, 1'b0);
    idle(20);
    check_output("glitch_dv_count", dv_count, exp_dv);
    check_output("glitch_fe_count", fe_count, exp_fe);

    // frame 0x3C with a bad stop bit
    apply_stimulus(8'h3C, ^8'h3C, 1'b0);
    exp_fe++;
    idle(32);
    check_output("bad_stop_fe_count", fe_count, exp_fe);
    check_output("bad_stop_dv_count", dv_count, exp_dv);
    check_output("bad_stop_data_kept", data_out, 8'hA5);

    // back-to-back 0x01 then 0xFE, no idle gap
    apply_stimulus(8'h01, ^8'h01, 1'b1);
    apply_stimulus(8'hFE, ^8'hFE, 1'b1);
    exp_dv += 2;
    idle(32);
    check_output("b2b_dv_count", dv_count, exp_dv);
    if (dv_vals.size() >= 2 && dv_cycles.size() >= 2) begin
      check_output("b2b_first_val", dv_vals[dv_vals.size()-2], 8'h01);
      check_output("b2b_second_val", dv_vals[dv_vals.size()-1], 8'hFE);
      diff = dv_cycles[dv_cycles.size()-1] - dv_cycles[dv_cycles.size()-2];
      $display("[TB] back-to-back pulse gap %0d cycles", diff);
      check_output("b2b_gap_ok", (diff >= FRAME_CYC - 2 && diff <= FRAME_CYC + 2), 1'b1);
    end else begin
      check_output("b2b_pulses_recorded", dv_vals.size(), 2);
    end

    // reset asserted in the middle of the data bits
    rx_in = 1'b0;
    repeat (CPB) @(negedge clock_in);
    rx_in = 1'b1;
    repeat (CPB) @(negedge clock_in);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clock_in);
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clock_in);
    check_output("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_output("mid_rst_data_out", data_out, 8'h00);
    check_output("mid_rst_busy", busy, 1'b0);
    check_output("mid_rst_data_valid", data_valid, 1'b0);
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    idle(40);
    check_output("mid_rst_no_pulse", dv_count, exp_dv);
    apply_stimulus(8'h55, ^8'h55, 1'b1);
    exp_dv++;
    idle(32);
    check_output("after_rst_dv_count", dv_count, exp_dv);
    check_output("after_rst_data_out", data_out, 8'h55);

`ifdef SERIAL_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    apply_stimulus(8'h07, 1'b1, 1'b1);
    exp_dv++;
    idle(32);
    check_output("par_good_dv_count", dv_count, exp_dv);
    check_output("par_good_data_out", data_out, 8'h07);
    apply_stimulus(8'h07, 1'b0, 1'b1);
    exp_fe++;
    idle(32);
    check_output("par_bad_fe_count", fe_count, exp_fe);
    check_output("par_bad_dv_count", dv_count, exp_dv);
`endif

    check_output("final_fe_count", fe_count, exp_fe);
    check_output("no_overlap", overlap_count, 0);
    check_output("no_wide_pulse", wide_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
